// File: rtl/sonar_pkg.sv
// Shared sonar definitions: FSM state codes, BCD digit type, default timing
// constants and the saturating 3-digit BCD increment.
package sonar_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [3:0] {
    ST_INICIAL       = 4'h0,
    ST_PREPARACAO    = 4'h1,
    ST_ENVIA_TRIGGER = 4'h2,
    ST_ESPERA_ECHO   = 4'h3,
    ST_MEDIDA        = 4'h4,
    ST_ARMAZENAMENTO = 4'h5,
    ST_FINAL_MEDIDA  = 4'hF
  } estado_t;

  localparam int unsigned TRIGGER_CYCLES_DEF = 500;
  localparam int unsigned CM_CYCLES_DEF      = 2941;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1_500_000;

  localparam logic [11:0] BCD_MAX = 12'h999;

  // Hundreds/tens/units increment with decimal carry; holds at 999.
  function automatic logic [11:0] bcd_inc_sat(input logic [11:0] v);
    bcd_digit_t c;
    bcd_digit_t d;
    bcd_digit_t u;
    c = v[11:8];
    d = v[7:4];
    u = v[3:0];
    if (v != BCD_MAX) begin
      if (u != 4'd9) begin
        u = u + 4'd1;
      end else begin
        u = '0;
        if (d != 4'd9) begin
          d = d + 4'd1;
        end else begin
          d = '0;
          c = c + 4'd1;
        end
      end
    end
    return {c, d, u};
  endfunction

endpackage

// File: rtl/contador_cm.sv
// Echo-width to centimetre counter: prescaler of CM_CYCLES clocks feeding a
// 3-digit saturating BCD counter, plus the round-half-up helpers.
module contador_cm
  import sonar_pkg::*;
#(
  parameter int unsigned CM_CYCLES = CM_CYCLES_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        limpa,
  input  logic        conta,
  output logic        metade,
  output logic [11:0] contagem,
  output logic [11:0] contagem_inc
);

  localparam int unsigned PW = (CM_CYCLES > 1) ? $clog2(CM_CYCLES) : 1;

  logic [PW-1:0] pre_q, pre_d;
  logic [11:0]   bcd_q, bcd_d;

  always_comb begin
    pre_d = pre_q;
    bcd_d = bcd_q;
    if (limpa) begin
      pre_d = '0;
      bcd_d = '0;
    end else if (conta) begin
      if (pre_q == PW'(CM_CYCLES - 1)) begin
        pre_d = '0;
        bcd_d = bcd_inc_sat(bcd_q);
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre_q <= '0;
      bcd_q <= '0;
    end else begin
      pre_q <= pre_d;
      bcd_q <= bcd_d;
    end
  end

  assign metade       = (pre_q >= PW'(CM_CYCLES / 2));
  assign contagem     = bcd_q;
  assign contagem_inc = bcd_inc_sat(bcd_q);

endmodule

// File: rtl/interface_hcsr04.sv
// HC-SR04 front-end: trigger generation, echo timing and BCD distance result.
// Optional no-echo timeout compiled in with HCSR04_TIMEOUT_EN.
module interface_hcsr04
  import sonar_pkg::*;
#(
  parameter int unsigned TRIGGER_CYCLES = TRIGGER_CYCLES_DEF,
  parameter int unsigned CM_CYCLES      = CM_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        medir,
  input  logic        echo,
  output logic        trigger,
  output logic [11:0] medida,
  output logic        pronto,
  output logic        erro,
  output logic [3:0]  db_estado
);

  localparam int unsigned TW = (TRIGGER_CYCLES > 1) ? $clog2(TRIGGER_CYCLES) : 1;

  estado_t       estado_q, estado_d;
  logic          echo_s1_q, echo_s1_d;
  logic          echo_s2_q, echo_s2_d;
  logic [TW-1:0] trig_cnt_q, trig_cnt_d;
  logic [11:0]   medida_q, medida_d;
  logic          limpa, conta;
  logic          metade;
  logic [11:0]   contagem, contagem_inc;

`ifdef HCSR04_TIMEOUT_EN
  localparam int unsigned OW = $clog2(TIMEOUT_CYCLES + 1);
  logic [OW-1:0] to_cnt_q, to_cnt_d;
  logic          erro_q, erro_d;
`else
  logic          timeout_unused;
  assign timeout_unused = (TIMEOUT_CYCLES != 0);
`endif

  contador_cm #(
    .CM_CYCLES (CM_CYCLES)
  ) u_contador_cm (
    .clock        (clock),
    .reset        (reset),
    .limpa        (limpa),
    .conta        (conta),
    .metade       (metade),
    .contagem     (contagem),
    .contagem_inc (contagem_inc)
  );

  assign echo_s1_d = echo;
  assign echo_s2_d = echo_s1_q;

  always_comb begin
    estado_d   = estado_q;
    trig_cnt_d = trig_cnt_q;
    medida_d   = medida_q;
    limpa      = 1'b0;
    conta      = 1'b0;
`ifdef HCSR04_TIMEOUT_EN
    to_cnt_d   = to_cnt_q;
    erro_d     = erro_q;
`endif
    unique case (estado_q)
      ST_INICIAL: begin
        if (medir) estado_d = ST_PREPARACAO;
      end
      ST_PREPARACAO: begin
        limpa      = 1'b1;
        trig_cnt_d = '0;
`ifdef HCSR04_TIMEOUT_EN
        to_cnt_d   = '0;
        erro_d     = 1'b0;
`endif
        estado_d   = ST_ENVIA_TRIGGER;
      end
      ST_ENVIA_TRIGGER: begin
        if (trig_cnt_q == TW'(TRIGGER_CYCLES - 1)) estado_d = ST_ESPERA_ECHO;
        else trig_cnt_d = trig_cnt_q + TW'(1);
      end
      ST_ESPERA_ECHO: begin
        // The cycle that detects the echo already counts, so the total equals
        // the number of clocks the synced echo stayed high.
        conta = echo_s2_q;
        if (echo_s2_q) estado_d = ST_MEDIDA;
      end
      ST_MEDIDA: begin
        conta = echo_s2_q;
        if (!echo_s2_q) estado_d = ST_ARMAZENAMENTO;
      end
      ST_ARMAZENAMENTO: begin
        medida_d = metade ? contagem_inc : contagem;
        estado_d = ST_FINAL_MEDIDA;
      end
      ST_FINAL_MEDIDA: begin
        estado_d = ST_INICIAL;
      end
      default: begin
        estado_d = ST_INICIAL;
      end
    endcase
`ifdef HCSR04_TIMEOUT_EN
    if (estado_q == ST_ESPERA_ECHO || estado_q == ST_MEDIDA) begin
      if (to_cnt_q == OW'(TIMEOUT_CYCLES - 1)) begin
        estado_d = ST_FINAL_MEDIDA;
        medida_d = BCD_MAX;
        erro_d   = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + OW'(1);
      end
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q   <= ST_INICIAL;
      echo_s1_q  <= 1'b0;
      echo_s2_q  <= 1'b0;
      trig_cnt_q <= '0;
      medida_q   <= '0;
`ifdef HCSR04_TIMEOUT_EN
      to_cnt_q   <= '0;
      erro_q     <= 1'b0;
`endif
    end else begin
      estado_q   <= estado_d;
      echo_s1_q  <= echo_s1_d;
      echo_s2_q  <= echo_s2_d;
      trig_cnt_q <= trig_cnt_d;
      medida_q   <= medida_d;
`ifdef HCSR04_TIMEOUT_EN
      to_cnt_q   <= to_cnt_d;
      erro_q     <= erro_d;
`endif
    end
  end

  assign trigger   = (estado_q == ST_ENVIA_TRIGGER);
  assign pronto    = (estado_q == ST_FINAL_MEDIDA);
  assign medida    = medida_q;
  assign db_estado = estado_q;
`ifdef HCSR04_TIMEOUT_EN
  assign erro      = erro_q;
`else
  assign erro      = 1'b0;
`endif

endmodule

// File: tb/tb_interface_hcsr04.sv
// Scoreboard bench for interface_hcsr04 with scaled timing (10/20/10000 clocks).
module tb_interface_hcsr04;

  localparam int unsigned TRIG = 10;
  localparam int unsigned CM   = 20;
  localparam int unsigned TO   = 10000;

  logic        clock = 1'b0;
  logic        reset;
  logic        medir;
  logic        echo;
  logic        trigger;
  logic [11:0] medida;
  logic        pronto;
  logic        erro;
  logic [3:0]  db_estado;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [11:0] medida;
    logic        erro;
  } exp_t;

  exp_t sb[$];

  always #5 clock = ~clock;

  interface_hcsr04 #(
    .TRIGGER_CYCLES (TRIG),
    .CM_CYCLES      (CM),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .medir     (medir),
    .echo      (echo),
    .trigger   (trigger),
    .medida    (medida),
    .pronto    (pronto),
    .erro      (erro),
    .db_estado (db_estado)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: every pronto pops one expected result.
  initial begin
    bit   prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clock);
      if (pronto === 1'b1) begin
        check("pronto_single_cycle", {31'd0, prev}, 32'd0);
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pronto: got pronto with medida %0h, expected no pronto", medida);
        end else begin
          e = sb.pop_front();
          check("medida", {20'd0, medida}, {20'd0, e.medida});
          check("erro", {31'd0, erro}, {31'd0, e.erro});
        end
      end
      prev = (pronto === 1'b1);
    end
  end

  task automatic do_measure(input int w, input logic [11:0] exp_m, input bit redo_medir);
    exp_t e;
    bit   to;
    int   cnt;
    int   lat;
    to = 1'b0;
`ifdef HCSR04_TIMEOUT_EN
    to = (w >= 9000);
`endif
    e.medida = to ? 12'h999 : exp_m;
    e.erro   = to;
    sb.push_back(e);

    @(negedge clock); medir = 1'b1;
    @(negedge clock); medir = 1'b0;
    check("estado_preparacao", {28'd0, db_estado}, 32'd1);
    check("trigger_low_in_prep", {31'd0, trigger}, 32'd0);
    @(negedge clock);
    check("estado_envia_trigger", {28'd0, db_estado}, 32'd2);
    cnt = 0;
    while (trigger === 1'b1 && cnt < 1000) begin
      cnt++;
      @(negedge clock);
    end
    check("trigger_width", cnt, TRIG);
    check("estado_espera_echo", {28'd0, db_estado}, 32'd3);

    repeat (20) @(negedge clock);
    echo = 1'b1;
    for (int i = 0; i < w; i++) begin
      @(negedge clock);
      medir = (redo_medir && i == w / 2);
    end
    echo  = 1'b0;
    medir = 1'b0;

    if (!to) begin
      lat = 0;
      do begin
        @(negedge clock);
        lat++;
      end while (pronto !== 1'b1 && lat < 100);
      check("pronto_latency", lat, 4);
    end
    cnt = 0;
    while (db_estado !== 4'd0 && cnt < 100) begin
      cnt++;
      @(negedge clock);
    end
    repeat (10) @(negedge clock);
    check("estado_inicial_after", {28'd0, db_estado}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    medir = 1'b0;
    echo  = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_trigger", {31'd0, trigger}, 32'd0);
    check("rst_pronto", {31'd0, pronto}, 32'd0);
    check("rst_erro", {31'd0, erro}, 32'd0);
    check("rst_medida", {20'd0, medida}, 32'h000);
    check("rst_estado", {28'd0, db_estado}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    do_measure(2000, 12'h100, 1'b0);
    do_measure(1506, 12'h075, 1'b0);
    do_measure(1095, 12'h055, 1'b0);
    do_measure(170,  12'h009, 1'b0);
    do_measure(169,  12'h008, 1'b0);
    do_measure(299,  12'h015, 1'b0);
    do_measure(300,  12'h015, 1'b1);

    // Reset in the middle of an echo.
    @(negedge clock); medir = 1'b1;
    @(negedge clock); medir = 1'b0;
    repeat (TRIG + 5) @(negedge clock);
    echo = 1'b1;
    repeat (100) @(negedge clock);
    check("estado_medida_before_rst", {28'd0, db_estado}, 32'd4);
    #2 reset = 1'b1;
    #1;
    check("midrst_trigger", {31'd0, trigger}, 32'd0);
    check("midrst_pronto", {31'd0, pronto}, 32'd0);
    check("midrst_erro", {31'd0, erro}, 32'd0);
    check("midrst_medida", {20'd0, medida}, 32'h000);
    check("midrst_estado", {28'd0, db_estado}, 32'd0);
    @(negedge clock);
    echo  = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clock);

    do_measure(1095,  12'h055, 1'b0);
    do_measure(20400, 12'h999, 1'b0);
    do_measure(19970, 12'h999, 1'b0);

    repeat (5) @(negedge clock);
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected end of test");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
